// File: rtl/axi_pkg.sv
// Shared AXI encodings, the write-responder state type and the 4 KB-crossing helper.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  localparam logic [2:0] SIZE_16B    = 3'h4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_DRAIN,
    ST_RESP
  } wr_state_e;

  // 13-bit sum: a 4 KB page offset plus up to 256 beats of 16 bytes never overflows.
  function automatic logic crosses_4k(input logic [11:0] offset, input logic [7:0] len);
    logic [12:0] span;
    span = ({5'd0, len} + 13'd1) << 4;
    return ({1'b0, offset} + span) > 13'd4096;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Burst address generator: holds start address, burst type, length and beat count,
// and flags the final beat and INCR bursts that would cross a 4 KB page.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_burst,
  input  logic [7:0]        ld_len,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              last_beat,
  output logic              cross_4k
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        burst_q, burst_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;

  always_comb begin
    addr_d  = addr_q;
    burst_d = burst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    if (load) begin
      addr_d  = ld_addr;
      burst_d = ld_burst;
      len_d   = ld_len;
      cnt_d   = '0;
    end else if (step) begin
      cnt_d = cnt_q + 8'd1;
      // FIXED bursts keep hitting the same address; address wraps modulo ADDR_W bits.
      if (burst_q == BURST_INCR) begin
        addr_d = addr_q + ADDR_W'(16);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      burst_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      burst_q <= burst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cur_addr  = addr_q;
  assign last_beat = (cnt_q == len_q);
  assign cross_4k  = (ld_burst == BURST_INCR) && crosses_4k(ld_addr[11:0], ld_len);

endmodule

// File: rtl/axi_wr_rsp_ctlr.sv
// AXI4 write responder: one transaction at a time, bursts split into single-beat
// downstream writes with zero-latency pass-through, B carries ID and accumulated error.
module axi_wr_rsp_ctlr
  import axi_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int ID_W   = 4,
  parameter int DATA_W = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [1:0]          awburst,
  input  logic [ID_W-1:0]     awid,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  output logic                WrValid,
  output logic [ADDR_W-1:0]   WrAddr,
  output logic [DATA_W-1:0]   WrData,
  output logic [DATA_W/8-1:0] WrStrb,
  input  logic                WrReady,
  input  logic                WrErr
);

  wr_state_e         state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              err_q, err_d;
  logic              bad_q, bad_d;
  logic              load, step;
  logic              bad_req;
  logic [ADDR_W-1:0] cur_addr;
  logic              last_beat;
  logic              cross_4k;

  axi_burst_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .ld_addr   (awaddr),
    .ld_burst  (awburst),
    .ld_len    (awlen),
    .cur_addr  (cur_addr),
    .last_beat (last_beat),
    .cross_4k  (cross_4k)
  );

  assign bad_req = (awsize != SIZE_16B) || (awburst == BURST_WRAP) ||
                   (awburst == 2'd3) || cross_4k;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    err_d   = err_q;
    bad_d   = bad_q;
    load    = 1'b0;
    step    = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    WrValid = 1'b0;
    bvalid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        awready = 1'b1;
        if (awvalid) begin
          load    = 1'b1;
          id_d    = awid;
          err_d   = 1'b0;
          bad_d   = bad_req;
          state_d = bad_req ? ST_DRAIN : ST_DATA;
        end
      end
      ST_DATA: begin
        WrValid = wvalid;
        wready  = WrReady;
        if (wvalid && WrReady) begin
          step  = 1'b1;
          err_d = err_q | WrErr;
          // wlast must coincide exactly with the final counted beat; either mismatch is an error.
          if (last_beat) begin
            if (!wlast) err_d = 1'b1;
            state_d = wlast ? ST_RESP : ST_DRAIN;
          end else if (wlast) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_DRAIN: begin
        wready = 1'b1;
        if (wvalid && wlast) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        bvalid = 1'b1;
        if (bready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Handshake outputs are forced quiet for the whole reset cycle, whatever state is held.
    if (rst) begin
      awready = 1'b0;
      wready  = 1'b0;
      WrValid = 1'b0;
      bvalid  = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
    end
  end

  assign WrAddr = rst ? '0 : cur_addr;
  assign WrData = wdata;
  assign WrStrb = wstrb;
  assign bid    = rst ? '0 : id_q;
  assign bresp  = (!rst && (err_q || bad_q)) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_wr_rsp_ctlr.sv
// Directed bench for axi_wr_rsp_ctlr: hand-computed write addresses, drain counts and B codes.
module tb_axi_wr_rsp_ctlr;

  logic         clk;
  logic         rst;
  logic [63:0]  awaddr;
  logic [1:0]   awburst;
  logic [3:0]   awid;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic         awvalid;
  logic         awready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic         WrValid;
  logic [63:0]  WrAddr;
  logic [127:0] WrData;
  logic [15:0]  WrStrb;
  logic         WrReady;
  logic         WrErr;

  int n_tests = 0;
  int n_fail  = 0;
  int drain_cnt = 0;
  logic tog = 1'b0;
  logic [63:0]  wr_addr_q [$];
  logic [127:0] wr_data_q [$];
  logic [15:0]  wr_strb_q [$];

  localparam logic [127:0] DATA_BASE = {16{8'hA5}};

  axi_wr_rsp_ctlr #(
    .ADDR_W (64),
    .ID_W   (4),
    .DATA_W (128)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .awaddr  (awaddr),
    .awburst (awburst),
    .awid    (awid),
    .awlen   (awlen),
    .awsize  (awsize),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bid     (bid),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .WrValid (WrValid),
    .WrAddr  (WrAddr),
    .WrData  (WrData),
    .WrStrb  (WrStrb),
    .WrReady (WrReady),
    .WrErr   (WrErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Downstream monitor: records accepted beats and counts beats swallowed without a write.
  always @(negedge clk) begin
    if (!rst && WrValid && WrReady) begin
      wr_addr_q.push_back(WrAddr);
      wr_data_q.push_back(WrData);
      wr_strb_q.push_back(WrStrb);
    end
    if (!rst && wvalid && wready && !WrValid) drain_cnt++;
  end

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, act, exp);
    end
  endtask

  task automatic run_xfer(input string nm, input logic [63:0] a, input logic [1:0] bu,
                          input logic [3:0] id, input logic [7:0] len, input logic [2:0] sz,
                          input int nbeats, input int last_idx, input int err_beat, input bit alt,
                          input int exp_nwr, input logic [63:0] exp_step,
                          input logic [1:0] exp_bresp, input int exp_drain);
    int g;
    bit done;
    logic [63:0] ea;
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_strb_q.delete();
    drain_cnt = 0;
    awaddr = a; awburst = bu; awid = id; awlen = len; awsize = sz; awvalid = 1'b1;
    WrReady = 1'b1;
    g = 0;
    done = 1'b0;
    while (!done && g < 10) begin
      @(negedge clk);
      done = awready;
      if (!done) begin
        @(posedge clk); #1;
        g++;
      end
    end
    check_eq({nm, "_aw_seen"}, done, 1'b1);
    check_eq({nm, "_wready_at_aw"}, wready, 1'b0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1'b1;
      wdata  = DATA_BASE + 128'(i);
      wstrb  = 16'hFFFF >> i;
      wlast  = (i == last_idx);
      WrErr  = (i == err_beat);
      g = 0;
      done = 1'b0;
      while (!done && g < 64) begin
        if (alt) begin
          WrReady = tog;
          tog = ~tog;
        end
        @(negedge clk);
        if (alt) check_eq({nm, "_wready_mirror"}, wready, WrReady);
        done = wready;
        @(posedge clk); #1;
        g++;
      end
      check_eq({nm, "_beat_accepted"}, done, 1'b1);
    end
    wvalid = 1'b0; wlast = 1'b0; WrErr = 1'b0; WrReady = 1'b1;
    @(negedge clk);
    check_eq({nm, "_b_latency"}, bvalid, 1'b1);
    g = 0;
    while (!bvalid && g < 10) begin
      @(negedge clk);
      g++;
    end
    check_eq({nm, "_bid"}, bid, id);
    check_eq({nm, "_bresp"}, bresp, exp_bresp);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq({nm, "_b_hold"}, {bvalid, bid, bresp}, {1'b1, id, exp_bresp});
    @(posedge clk); #1;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    check_eq({nm, "_awready_after_b"}, {awready, bvalid}, 2'b10);
    check_eq({nm, "_nwrites"}, wr_addr_q.size(), exp_nwr);
    for (int k = 0; k < wr_addr_q.size() && k < exp_nwr; k++) begin
      ea = a + 64'(k) * exp_step;
      check_eq({nm, "_wr_addr"}, wr_addr_q[k], ea);
      check_eq({nm, "_wr_data"}, wr_data_q[k], DATA_BASE + 128'(k));
      check_eq({nm, "_wr_strb"}, wr_strb_q[k], 16'hFFFF >> k);
    end
    check_eq({nm, "_drained"}, drain_cnt, exp_drain);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; awburst = 2'd1; awid = '0; awlen = '0; awsize = 3'h4; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    WrReady = 1'b1; WrErr = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("reset_ctrl", {awready, wready, bvalid, WrValid}, 4'b0000);
    check_eq("reset_b", {bid, bresp}, 6'd0);
    check_eq("reset_wraddr", WrAddr, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("awready_after_reset", awready, 1'b1);
    @(posedge clk); #1;

    //        name      addr         burst id     len   size  nb lst err alt nwr step   bresp drn
    run_xfer("single",  64'h1000, 2'd1, 4'd5,  8'd0, 3'h4, 1, 0, -1, 0, 1, 64'd16, 2'd0, 0);
    run_xfer("incr4",   64'h2000, 2'd1, 4'd3,  8'd3, 3'h4, 4, 3, -1, 1, 4, 64'd16, 2'd0, 0);
    run_xfer("fixed3",  64'h3000, 2'd0, 4'd7,  8'd2, 3'h4, 3, 2,  1, 0, 3, 64'd0,  2'd2, 0);
    run_xfer("wrap",    64'h5000, 2'd2, 4'd2,  8'd1, 3'h4, 2, 1, -1, 0, 0, 64'd16, 2'd2, 2);
    run_xfer("cross4k", 64'h0FF0, 2'd1, 4'd9,  8'd1, 3'h4, 2, 1, -1, 0, 0, 64'd16, 2'd2, 2);
    run_xfer("edge4k",  64'h0FE0, 2'd1, 4'd10, 8'd1, 3'h4, 2, 1, -1, 0, 2, 64'd16, 2'd0, 0);
    run_xfer("early",   64'h6000, 2'd1, 4'd1,  8'd2, 3'h4, 1, 0, -1, 0, 1, 64'd16, 2'd2, 0);
    run_xfer("nolast",  64'h7000, 2'd1, 4'd4,  8'd1, 3'h4, 3, 2, -1, 0, 2, 64'd16, 2'd2, 1);
    run_xfer("badsize", 64'h8000, 2'd1, 4'd8,  8'd0, 3'h3, 1, 0, -1, 0, 0, 64'd16, 2'd2, 1);

    // Reset after one of four beats: transaction is dropped without a B.
    wr_addr_q.delete();
    awaddr = 64'h4000; awburst = 2'd1; awid = 4'd11; awlen = 8'd3; awsize = 3'h4; awvalid = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_aw", awready, 1'b1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b1; wlast = 1'b0; wdata = DATA_BASE; wstrb = 16'hFFFF;
    @(negedge clk);
    check_eq("rst_mid_beat0", {wready, WrValid}, 2'b11);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_quiet", {awready, wready, bvalid, WrValid}, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_after", {awready, bvalid, WrValid}, 3'b100);
    @(posedge clk); #1;
    wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rst_mid_no_b", {bvalid, WrValid}, 2'b00);
      @(posedge clk); #1;
    end
    check_eq("rst_mid_writes", wr_addr_q.size(), 1);

    run_xfer("post_rst", 64'h9000, 2'd1, 4'd6, 8'd0, 3'h4, 1, 0, -1, 0, 1, 64'd16, 2'd0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_wr_rsp_ctlr.md
# axi_wr_rsp_ctlr

AXI4 write responder (slave) for the PCIe DMA AXI-MM fabric. It accepts one 128-bit write transaction at a time on AW/W and splits bursts into single-beat downstream register/memory write requests. It returns a B response carrying the captured ID and an accumulated error status. It is the target-side counterpart of the single-beat AXI write requester used by the DMA controllers.

## Interface
Parameters:
- ADDR_W, 64, AXI address width
- ID_W, 4, AXI ID width
- DATA_W, 128, data width; fixed, 16-byte beats (awsize 3'h4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- awaddr  in  ADDR_W  write address
- awburst  in  2  0=FIXED, 1=INCR, 2=WRAP
- awid  in  ID_W  transaction ID
- awlen  in  8  beats-1
- awsize  in  3  beat size
- awvalid  in  1  address valid
- awready  out  1  address accept
- wdata  in  DATA_W  write data
- wstrb  in  16  byte enables
- wlast  in  1  last beat
- wvalid  in  1  data valid
- wready  out  1  data accept
- bid  out  ID_W  response ID
- bresp  out  2  0=OKAY, 2=SLVERR
- bvalid  out  1  response valid
- bready  in  1  response accept
- WrValid  out  1  downstream beat valid
- WrAddr  out  ADDR_W  downstream beat address
- WrData  out  DATA_W  downstream beat data
- WrStrb  out  16  downstream byte enables
- WrReady  in  1  downstream accept
- WrErr  in  1  downstream error, sampled when WrValid&WrReady

## Operation
- States: IDLE, DATA, DRAIN, RESP. One transaction in flight; no AW/W interleave or reordering.
- IDLE: awready=1. On awvalid, capture awaddr, awid, awlen, awburst into registers, clear the beat counter, and set Err=0.
  - Unsupported requests set Bad=1 and go to DRAIN: awsize≠4, awburst=WRAP or 3, or an INCR burst crossing a 4 KB boundary (awaddr[11:0] + 16·(awlen+1) > 4096).
  - Otherwise go to DATA.
- DATA: WrValid=wvalid; wready=WrReady; WrAddr=current address; WrData/WrStrb pass through from W. On each beat transfer (wvalid&wready):
  - Err |= WrErr.
  - Counter increments.
  - Address advances by 16 for INCR; unchanged for FIXED.
  - wlast with counter<awlen (early last): Err=1, go to RESP.
  - counter==awlen with wlast: go to RESP.
  - counter==awlen without wlast: Err=1, go to DRAIN.
- DRAIN: wready=1, WrValid=0. Beats are discarded until wlast; then go to RESP with Err=1.
- RESP: bvalid=1, bid=captured ID, bresp = 2 if (Err|Bad), else 0. On bready go to IDLE.
- Address arithmetic is ADDR_W-bit modulo. The 4 KB check uses a 13-bit sum.

## Timing
- Reset: state=IDLE; all registers clear. While rst=1: awready, wready, bvalid, WrValid are all 0, and bid=0, bresp=0, WrAddr=0. awready=1 on the first cycle after rst deasserts.
- An AW handshake in cycle N puts the block in DATA in N+1. wready is never asserted in the same cycle as the AW handshake.
- Zero-latency data path: a W beat and the downstream beat transfer in the same cycle. Downstream backpressure (WrReady=0) holds wready=0.
- A final beat accepted in N makes bvalid=1 in N+1. bvalid holds with stable bid/bresp until bready.
- A B handshake in cycle M gives awready=1 in M+1, so minimum transaction turnaround is awlen+3 cycles.
- Reset mid-transaction drops the transaction: no B is issued, and no WrValid appears after the reset cycle.

## Structure
- A shared package axi_pkg holds the burst encodings (FIXED/INCR/WRAP), response codes (OKAY/SLVERR), the size constant SIZE_16B=3'h4, and the state enum typedef.
- One natural sub-module is axi_burst_addr_gen. It holds the start address, burst type and count, and provides the next address, the last-beat flag and the 4 KB-cross detect.

## Test plan
- Single beat: AW addr=0x1000, len=0, INCR, id=5; W data=0xA5…, wlast=1 -> one downstream write at 0x1000; bid=5, bresp=0.
- INCR burst: addr=0x2000, len=3, with WrReady low every other cycle -> writes at 0x2000/0x2010/0x2020/0x2030, wready mirroring WrReady, bresp=0.
- FIXED burst: len=2, addr=0x3000 -> three writes, all at 0x3000; WrErr=1 on beat 1 gives bresp=2.
- Unsupported: WRAP, or INCR with addr=0xFF0 and len=1 (crosses 4 KB) -> no WrValid, 2 beats drained, bresp=2.
- wlast errors: wlast on beat 0 of a len=2 burst -> RESP immediately, bresp=2. Missing wlast on the last beat -> DRAIN until wlast, bresp=2.
- Reset during DATA after 1 of 4 beats -> no bvalid; awready=1 on the cycle after rst drops; the next transaction completes with bresp=0.
